// File: rtl/decode_issue_queue_if.sv
// Decode/issue queue bus: fetch-side push channel, downstream availability
// flags, and the registered issue bundle.
//   master : fetch/dispatch side (drives rdy, flush, in_*, *_avail)
//   slave  : the queue (drives in_ready and all issue outputs)
interface decode_issue_queue_if #(
    parameter int unsigned ROB_W = 4
);
    logic              rdy;
    logic              flush;
    logic              in_valid;
    logic [31:0]       in_inst;
    logic [31:0]       in_pc;
    logic              in_jump;
    logic              in_ready;
    logic              rob_avail;
    logic              rs_avail;
    logic              slb_avail;
    logic [ROB_W-1:0]  rob_avail_num;
    logic              issue_valid;
    logic [1:0]        issue_unit;
    logic [5:0]        op;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic [1:0]        inst_type;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              need_rs1;
    logic              need_rs2;
    logic              set_busy;
    logic              has_jump;
    logic              illegal;
    logic [ROB_W-1:0]  rob_tag;

    modport master (
        output rdy, flush, in_valid, in_inst, in_pc, in_jump,
               rob_avail, rs_avail, slb_avail, rob_avail_num,
        input  in_ready, issue_valid, issue_unit, op, imm, pc, inst_type,
               rd, rs1, rs2, need_rs1, need_rs2, set_busy, has_jump,
               illegal, rob_tag
    );

    modport slave (
        input  rdy, flush, in_valid, in_inst, in_pc, in_jump,
               rob_avail, rs_avail, slb_avail, rob_avail_num,
        output in_ready, issue_valid, issue_unit, op, imm, pc, inst_type,
               rd, rs1, rs2, need_rs1, need_rs2, set_busy, has_jump,
               illegal, rob_tag
    );
endinterface

// File: rtl/decode_issue_queue.sv
// Circular instruction queue between fetch and issue. The head entry is
// decoded combinationally (RV32I) and, when its target unit and the ROB have
// room, registered onto the issue bundle with a one-cycle issue_valid pulse.
// Ports: clk, rst (synchronous, active-high), q (slave side of
// decode_issue_queue_if: rdy/flush/push inputs, avail flags, issue outputs).
module decode_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned ROB_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_issue_queue_if.slave  q
);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] UNIT_RS  = 2'b00;
    localparam logic [1:0] UNIT_SLB = 2'b01;
    localparam logic [1:0] UNIT_ROB = 2'b10;

    localparam logic [1:0] TYPE_OTHER  = 2'd0;
    localparam logic [1:0] TYPE_JALR   = 2'd1;
    localparam logic [1:0] TYPE_BRANCH = 2'd2;
    localparam logic [1:0] TYPE_STORE  = 2'd3;

    // Op encoding shared with the rest of the core.
    localparam logic [5:0] OP_NOP = 6'd0,  OP_LUI = 6'd1,  OP_AUIPC = 6'd2,
                           OP_JAL = 6'd3,  OP_JALR = 6'd4,
                           OP_BEQ = 6'd5,  OP_BNE = 6'd6,  OP_BLT = 6'd7,
                           OP_BGE = 6'd8,  OP_BLTU = 6'd9, OP_BGEU = 6'd10,
                           OP_LB = 6'd11,  OP_LH = 6'd12,  OP_LW = 6'd13,
                           OP_LBU = 6'd14, OP_LHU = 6'd15,
                           OP_SB = 6'd16,  OP_SH = 6'd17,  OP_SW = 6'd18,
                           OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21,
                           OP_XORI = 6'd22, OP_ORI = 6'd23,  OP_ANDI = 6'd24,
                           OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
                           OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30,
                           OP_SLT = 6'd31, OP_SLTU = 6'd32, OP_XOR = 6'd33,
                           OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36,
                           OP_AND = 6'd37;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [DEPTH-1:0] jump_mem;

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             enq, deq, avail_ok;

    logic [31:0] h_inst;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

    logic [1:0]  d_unit, d_type;
    logic [5:0]  d_op;
    logic [31:0] d_imm;
    logic [4:0]  d_rd, d_rs1, d_rs2;
    logic        d_need1, d_need2, d_wr, d_ill, d_busy;

    assign h_inst = inst_mem[head];
    assign opcode = h_inst[6:0];
    assign f3     = h_inst[14:12];
    assign f7     = h_inst[31:25];

    assign imm_i  = {{20{h_inst[31]}}, h_inst[31:20]};
    assign imm_s  = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
    assign imm_b  = {{20{h_inst[31]}}, h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
    assign imm_u  = {h_inst[31:12], 12'h000};
    assign imm_j  = {{12{h_inst[31]}}, h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};
    assign imm_sh = {27'd0, h_inst[24:20]};

    // Head-entry decode; anything unrecognised collapses to a ROB-only illegal.
    always_comb begin
        d_unit  = UNIT_RS;
        d_type  = TYPE_OTHER;
        d_op    = OP_NOP;
        d_imm   = '0;
        d_rd    = h_inst[11:7];
        d_rs1   = h_inst[19:15];
        d_rs2   = h_inst[24:20];
        d_need1 = 1'b0;
        d_need2 = 1'b0;
        d_wr    = 1'b0;
        d_ill   = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                d_op  = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
                d_imm = imm_u;
                d_rs1 = '0;
                d_rs2 = '0;
                d_wr  = 1'b1;
            end
            OPC_JAL: begin
                d_op  = OP_JAL;
                d_imm = imm_j;
                d_rs1 = '0;
                d_rs2 = '0;
                d_wr  = 1'b1;
            end
            OPC_JALR: begin
                d_op    = OP_JALR;
                d_imm   = imm_i;
                d_rs2   = '0;
                d_need1 = 1'b1;
                d_wr    = 1'b1;
                d_type  = TYPE_JALR;
                d_ill   = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d_imm   = imm_b;
                d_rd    = '0;
                d_need1 = 1'b1;
                d_need2 = 1'b1;
                d_type  = TYPE_BRANCH;
                case (f3)
                    3'b000:  d_op = OP_BEQ;
                    3'b001:  d_op = OP_BNE;
                    3'b100:  d_op = OP_BLT;
                    3'b101:  d_op = OP_BGE;
                    3'b110:  d_op = OP_BLTU;
                    3'b111:  d_op = OP_BGEU;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d_unit  = UNIT_SLB;
                d_imm   = imm_i;
                d_rs2   = '0;
                d_need1 = 1'b1;
                d_wr    = 1'b1;
                case (f3)
                    3'b000:  d_op = OP_LB;
                    3'b001:  d_op = OP_LH;
                    3'b010:  d_op = OP_LW;
                    3'b100:  d_op = OP_LBU;
                    3'b101:  d_op = OP_LHU;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                d_unit  = UNIT_SLB;
                d_imm   = imm_s;
                d_rd    = '0;
                d_need1 = 1'b1;
                d_need2 = 1'b1;
                d_type  = TYPE_STORE;
                case (f3)
                    3'b000:  d_op = OP_SB;
                    3'b001:  d_op = OP_SH;
                    3'b010:  d_op = OP_SW;
                    default: d_ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                d_imm   = imm_i;
                d_rs2   = '0;
                d_need1 = 1'b1;
                d_wr    = 1'b1;
                case (f3)
                    3'b000:  d_op = OP_ADDI;
                    3'b010:  d_op = OP_SLTI;
                    3'b011:  d_op = OP_SLTIU;
                    3'b100:  d_op = OP_XORI;
                    3'b110:  d_op = OP_ORI;
                    3'b111:  d_op = OP_ANDI;
                    3'b001: begin
                        d_op  = OP_SLLI;
                        d_imm = imm_sh;
                        d_ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        d_imm = imm_sh;
                        if (f7 == 7'b0000000)      d_op  = OP_SRLI;
                        else if (f7 == 7'b0100000) d_op  = OP_SRAI;
                        else                       d_ill = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                d_need1 = 1'b1;
                d_need2 = 1'b1;
                d_wr    = 1'b1;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  d_op = OP_ADD;
                        3'b001:  d_op = OP_SLL;
                        3'b010:  d_op = OP_SLT;
                        3'b011:  d_op = OP_SLTU;
                        3'b100:  d_op = OP_XOR;
                        3'b101:  d_op = OP_SRL;
                        3'b110:  d_op = OP_OR;
                        default: d_op = OP_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d_op = OP_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    d_op = OP_SRA;
                end else begin
                    d_ill = 1'b1;
                end
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_unit  = UNIT_ROB;
            d_type  = TYPE_OTHER;
            d_op    = OP_NOP;
            d_imm   = '0;
            d_rd    = '0;
            d_rs1   = '0;
            d_rs2   = '0;
            d_need1 = 1'b0;
            d_need2 = 1'b0;
            d_wr    = 1'b0;
        end
    end

    assign d_busy = d_wr && (d_rd != 5'd0);

    // Fullness only; a same-cycle dequeue never frees a slot early.
    assign q.in_ready = (count != CNT_W'(DEPTH));

    assign avail_ok = (d_unit == UNIT_RS)  ? q.rs_avail  :
                      (d_unit == UNIT_SLB) ? q.slb_avail : 1'b1;
    assign enq = q.in_valid && q.in_ready && q.rdy && !q.flush;
    assign deq = (count != '0) && q.rdy && !q.flush && q.rob_avail && avail_ok;

    // Payload storage; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            inst_mem[tail] <= q.in_inst;
            pc_mem[tail]   <= q.in_pc;
            jump_mem[tail] <= q.in_jump;
        end
    end

    // Pointers, occupancy and the registered issue bundle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            q.issue_valid <= 1'b0;
            q.issue_unit  <= '0;
            q.op          <= '0;
            q.imm         <= '0;
            q.pc          <= '0;
            q.inst_type   <= '0;
            q.rd          <= '0;
            q.rs1         <= '0;
            q.rs2         <= '0;
            q.need_rs1    <= 1'b0;
            q.need_rs2    <= 1'b0;
            q.set_busy    <= 1'b0;
            q.has_jump    <= 1'b0;
            q.illegal     <= 1'b0;
            q.rob_tag     <= '0;
        end else if (q.flush) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            q.issue_valid <= 1'b0;
        end else if (q.rdy) begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
            q.issue_valid <= deq;
            if (deq) begin
                q.issue_unit <= d_unit;
                q.op         <= d_op;
                q.imm        <= d_imm;
                q.pc         <= pc_mem[head];
                q.inst_type  <= d_type;
                q.rd         <= d_rd;
                q.rs1        <= d_rs1;
                q.rs2        <= d_rs2;
                q.need_rs1   <= d_need1;
                q.need_rs2   <= d_need2;
                q.set_busy   <= d_busy;
                q.has_jump   <= jump_mem[head];
                q.illegal    <= d_ill;
                q.rob_tag    <= q.rob_avail_num;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_queue.sv
module tb_decode_issue_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned ROB_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_issue_queue_if #(.ROB_W(ROB_W)) bus ();
    decode_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  unit;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [1:0]  itype;
        logic [4:0]  rd, rs1, rs2;
        logic        n1, n2, busy, ill;
    } dec_t;

    typedef struct {
        logic [31:0] inst, pc;
        logic        jump;
    } ent_t;

    // RV32I base instruction match table (mask/match); op code = index+1.
    logic [31:0] pat_mask [37] = '{
        32'h7F, 32'h7F, 32'h7F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F};
    logic [31:0] pat_match [37] = '{
        32'h37, 32'h17, 32'h6F, 32'h67,
        32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
        32'h03, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
        32'h23, 32'h1023, 32'h2023,
        32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
        32'h1013, 32'h5013, 32'h40005013,
        32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
        32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};

    function automatic int match_op(input logic [31:0] i);
        for (int k = 0; k < 37; k++)
            if ((i & pat_mask[k]) == pat_match[k]) return k + 1;
        return 0;
    endfunction

    function automatic dec_t zero_dec();
        dec_t d;
        d.unit = 2'd0; d.op = 6'd0; d.imm = 32'd0; d.itype = 2'd0;
        d.rd = 5'd0; d.rs1 = 5'd0; d.rs2 = 5'd0;
        d.n1 = 1'b0; d.n2 = 1'b0; d.busy = 1'b0; d.ill = 1'b0;
        return d;
    endfunction

    // Reference decode by instruction class (op number ranges of the table).
    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        int   op;
        bit   is_b, is_s, is_r, use1, use2, wr;
        logic signed [20:0] joff;
        logic signed [12:0] boff;
        d  = zero_dec();
        op = match_op(i);
        if (op == 0) begin
            d.unit = 2'd2;
            d.ill  = 1'b1;
            return d;
        end
        is_b = (op >= 5 && op <= 10);
        is_s = (op >= 16 && op <= 18);
        is_r = (op >= 28);
        use1 = (op > 3);
        use2 = is_b || is_s || is_r;
        wr   = !(is_b || is_s);
        d.op    = 6'(op);
        d.unit  = (op >= 11 && op <= 18) ? 2'd1 : 2'd0;
        d.itype = (op == 4) ? 2'd1 : is_b ? 2'd2 : is_s ? 2'd3 : 2'd0;
        joff = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        boff = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (op <= 2)                d.imm = {i[31:12], 12'h000};
        else if (op == 3)           d.imm = 32'(joff);
        else if (is_b)              d.imm = 32'(boff);
        else if (is_s)              d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        else if (op >= 25 && op <= 27) d.imm = 32'(i[24:20]);
        else if (is_r)              d.imm = 32'd0;
        else                        d.imm = {{20{i[31]}}, i[31:20]};
        d.rd   = wr   ? i[11:7]  : 5'd0;
        d.rs1  = use1 ? i[19:15] : 5'd0;
        d.rs2  = use2 ? i[24:20] : 5'd0;
        d.n1   = use1;
        d.n2   = use2;
        d.busy = wr && (d.rd != 5'd0);
        return d;
    endfunction

    function automatic logic [31:0] gen_inst();
        int k;
        if ($urandom_range(0, 7) == 0) return $urandom();
        k = $urandom_range(0, 36);
        return ($urandom() & ~pat_mask[k]) | pat_match[k];
    endfunction

    ent_t             mq[$];
    logic             e_valid;
    dec_t             e_dec;
    logic [31:0]      e_pc;
    logic             e_jump;
    logic [ROB_W-1:0] e_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, advance, compare every output.
    task automatic cycle();
        bit   enq, deq;
        dec_t hd;
        chk("in_ready_pre", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
        if (rst) begin
            mq.delete();
            e_valid = 1'b0; e_dec = zero_dec(); e_pc = '0; e_jump = 1'b0; e_tag = '0;
        end else if (bus.flush) begin
            mq.delete();
            e_valid = 1'b0;
        end else if (bus.rdy) begin
            enq = bus.in_valid && (mq.size() != DEPTH);
            deq = 1'b0;
            if (mq.size() > 0) begin
                hd  = ref_decode(mq[0].inst);
                deq = bus.rob_avail && ((hd.unit == 2'd0) ? bus.rs_avail :
                                        (hd.unit == 2'd1) ? bus.slb_avail : 1'b1);
            end
            e_valid = deq;
            if (deq) begin
                e_dec  = hd;
                e_pc   = mq[0].pc;
                e_jump = mq[0].jump;
                e_tag  = bus.rob_avail_num;
                void'(mq.pop_front());
            end
            if (enq) mq.push_back('{inst: bus.in_inst, pc: bus.in_pc, jump: bus.in_jump});
        end
        @(posedge clk);
        #1;
        chk("issue_valid", 32'(bus.issue_valid), 32'(e_valid));
        chk("issue_unit",  32'(bus.issue_unit),  32'(e_dec.unit));
        chk("op",          32'(bus.op),          32'(e_dec.op));
        chk("imm",         bus.imm,              e_dec.imm);
        chk("pc",          bus.pc,               e_pc);
        chk("inst_type",   32'(bus.inst_type),   32'(e_dec.itype));
        chk("rd",          32'(bus.rd),          32'(e_dec.rd));
        chk("rs1",         32'(bus.rs1),         32'(e_dec.rs1));
        chk("rs2",         32'(bus.rs2),         32'(e_dec.rs2));
        chk("need_rs1",    32'(bus.need_rs1),    32'(e_dec.n1));
        chk("need_rs2",    32'(bus.need_rs2),    32'(e_dec.n2));
        chk("set_busy",    32'(bus.set_busy),    32'(e_dec.busy));
        chk("has_jump",    32'(bus.has_jump),    32'(e_jump));
        chk("illegal",     32'(bus.illegal),     32'(e_dec.ill));
        chk("rob_tag",     32'(bus.rob_tag),     32'(e_tag));
    endtask

    task automatic push(input logic [31:0] inst);
        bus.in_valid      = 1'b1;
        bus.in_inst       = inst;
        bus.in_pc         = $urandom();
        bus.in_jump       = 1'($urandom_range(0, 1));
        bus.rob_avail_num = ROB_W'($urandom());
        cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.rob_avail_num = ROB_W'($urandom());
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.rdy = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.in_inst = '0; bus.in_pc = '0; bus.in_jump = 1'b0;
        bus.rob_avail = 1'b1; bus.rs_avail = 1'b1; bus.slb_avail = 1'b1;
        bus.rob_avail_num = '0;
        e_valid = 1'b0; e_dec = zero_dec(); e_pc = '0; e_jump = 1'b0; e_tag = '0;

        // Reset state
        @(posedge clk);
        #1;
        cycle();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        rst = 1'b0;

        // addi x5,x0,7: issues on the second edge
        push(32'h00700293);
        chk("addi_not_yet", 32'(bus.issue_valid), 32'd0);
        idle(1);
        chk("addi_valid", 32'(bus.issue_valid), 32'd1);
        chk("addi_unit", 32'(bus.issue_unit), 32'd0);
        chk("addi_op", 32'(bus.op), 32'd19);
        chk("addi_imm", bus.imm, 32'd7);
        chk("addi_rd", 32'(bus.rd), 32'd5);
        chk("addi_rs1", 32'(bus.rs1), 32'd0);
        chk("addi_need_rs1", 32'(bus.need_rs1), 32'd1);
        chk("addi_set_busy", 32'(bus.set_busy), 32'd1);
        idle(1);

        // Fill to DEPTH with RS blocked, offer one extra, then drain in order
        bus.rs_avail = 1'b0;
        for (int k = 0; k < DEPTH; k++) push(32'h00000093 | (32'(k + 1) << 20));
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        push(32'h06300093);
        bus.rs_avail = 1'b1;
        idle(1);
        chk("drain_first_imm", bus.imm, 32'd1);
        idle(DEPTH);
        chk("drained_in_ready", 32'(bus.in_ready), 32'd1);

        // sw x2,8(x1) waits on SLB
        bus.slb_avail = 1'b0;
        push(32'h0020A423);
        idle(3);
        chk("sw_blocked", 32'(bus.issue_valid), 32'd0);
        bus.slb_avail = 1'b1;
        idle(1);
        chk("sw_valid", 32'(bus.issue_valid), 32'd1);
        chk("sw_unit", 32'(bus.issue_unit), 32'd1);
        chk("sw_type", 32'(bus.inst_type), 32'd3);
        chk("sw_imm", bus.imm, 32'd8);
        chk("sw_rd", 32'(bus.rd), 32'd0);
        chk("sw_busy", 32'(bus.set_busy), 32'd0);
        idle(1);

        // Flush with three queued entries
        bus.rs_avail = 1'b0;
        for (int k = 0; k < 3; k++) push(gen_inst() & 32'hFFFF_FF80 | 32'h13);
        bus.flush = 1'b1;
        idle(1);
        bus.flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_issue_valid", 32'(bus.issue_valid), 32'd0);
        bus.rs_avail = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("flush_no_stale", 32'(bus.issue_valid), 32'd0);
        end

        // Illegal opcode and a write to x0
        push(32'h0000007F);
        idle(1);
        chk("ill_unit", 32'(bus.issue_unit), 32'd2);
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        push(32'h00208033);
        idle(1);
        chk("add_x0_valid", 32'(bus.issue_valid), 32'd1);
        chk("add_x0_busy", 32'(bus.set_busy), 32'd0);
        idle(1);

        // rdy low freezes everything
        bus.rob_avail = 1'b0;
        push(32'h00A00513);
        bus.rdy = 1'b0; bus.rob_avail = 1'b1; bus.in_valid = 1'b1; bus.in_inst = 32'h00B00593;
        idle(3);
        chk("frozen_no_issue", 32'(bus.issue_valid), 32'd0);
        bus.in_valid = 1'b0; bus.rdy = 1'b1;
        idle(1);
        chk("unfrozen_issue", 32'(bus.issue_valid), 32'd1);
        bus.rdy = 1'b0;
        idle(2);
        chk("frozen_valid_held", 32'(bus.issue_valid), 32'd1);
        bus.rdy = 1'b1;
        idle(1);

        // Random traffic: wraps pointers many times
        for (int n = 0; n < 400; n++) begin
            bus.rdy       = ($urandom_range(0, 7) != 0);
            bus.flush     = ($urandom_range(0, 39) == 0);
            bus.rob_avail = ($urandom_range(0, 3) != 0);
            bus.rs_avail  = ($urandom_range(0, 3) != 0);
            bus.slb_avail = ($urandom_range(0, 3) != 0);
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_inst   = gen_inst();
            bus.in_pc     = $urandom();
            bus.in_jump   = 1'($urandom_range(0, 1));
            bus.rob_avail_num = ROB_W'($urandom());
            cycle();
        end
        bus.flush = 1'b0; bus.rdy = 1'b1; bus.in_valid = 1'b0;
        bus.rob_avail = 1'b1; bus.slb_avail = 1'b1;

        // Reset mid-operation overrides flush/rdy and discards entries
        bus.rs_avail = 1'b0;
        for (int k = 0; k < 3; k++) push(32'h00100093);
        rst = 1'b1; bus.flush = 1'b1; bus.rdy = 1'b0;
        idle(1);
        rst = 1'b0; bus.flush = 1'b0; bus.rdy = 1'b1; bus.rs_avail = 1'b1;
        chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst2_op", 32'(bus.op), 32'd0);
        idle(3);
        chk("rst2_no_issue", 32'(bus.issue_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL take parameter DEPTH, default 4, meaning instruction queue entries; must be a power of two, 2..32.
REQ-002 SHALL take parameter PTR_W, default $clog2(DEPTH), meaning head/tail pointer width.
REQ-003 SHALL take parameter ROB_W, default 4, meaning ROB tag width.
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rdy  in  1  global enable; when low, all state and outputs are frozen.
REQ-007 flush  in  1  misbranch flush.
REQ-008 in_valid  in  1  fetcher offers an instruction.
REQ-009 in_inst, in_pc  in  32 each  instruction word and its PC.
REQ-010 in_jump  in  1  fetcher predicted taken.
REQ-011 in_ready  out  1  queue can accept.
REQ-012 rob_avail, rs_avail, slb_avail  in  1 each  downstream free-slot flags.
REQ-013 rob_avail_num  in  ROB_W  tag for the next ROB entry.
REQ-014 issue_valid  out  1  one-cycle issue pulse.
REQ-015 issue_unit  out  2  00 RS, 01 SLB, 10 ROB-only.
REQ-016 op  out  6  op_* encoding per config.v.
REQ-017 imm, pc  out  32 each  decoded immediate and PC.
REQ-018 inst_type  out  2  Other/Jalr/Branch/Store_Type.
REQ-019 rd, rs1, rs2  out  5 each  register addresses.
REQ-020 need_rs1, need_rs2, set_busy, has_jump, illegal  out  1 each  decode flags.
REQ-021 rob_tag  out  ROB_W  tag latched from rob_avail_num.

Function
REQ-022 SHALL implement a circular queue with head and tail pointers of PTR_W bits and a count of PTR_W+1 bits; pointers SHALL wrap DEPTH-1 -> 0.
REQ-023 in_ready SHALL equal (count != DEPTH) combinationally, with no dependence on same-cycle dequeue.
REQ-024 Enqueue SHALL occur when in_valid && in_ready && rdy && !flush.
REQ-025 Head target SHALL be decoded from opcode: Load/Store -> SLB; Lui/Auipc/Jal/Jalr/Branch/OP-IMM/OP -> RS; any other opcode -> ROB-only with illegal=1.
REQ-026 Dequeue SHALL occur when count>0 && rdy && !flush && rob_avail && (target RS ? rs_avail : target SLB ? slb_avail : 1).
REQ-027 On dequeue, the decoded fields SHALL be registered and issue_valid SHALL be 1 for exactly the following cycle; otherwise issue_valid=0 and the other outputs hold their values.
REQ-028 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-029 There is no empty-queue bypass: an instruction accepted at edge k SHALL produce issue_valid no earlier than after edge k+1.
REQ-030 Immediate decode SHALL use I/S/B/U/J formats sign-extended to 32 bits; slli/srli/srai SHALL place zero-extended inst[24:20] in imm.
REQ-031 rd SHALL be forced to 0 for Branch and Store; rs1 and rs2 SHALL be forced to 0 when unused (Lui/Auipc/Jal rs1 and rs2; Jalr/Load/OP-IMM rs2).
REQ-032 set_busy SHALL be 1 only for register-writing instructions with rd != 0.
REQ-033 An unknown funct3/funct7 under a known opcode SHALL set illegal=1 and issue ROB-only.
REQ-034 flush SHALL have priority over rdy: next edge head=tail=count=0 and issue_valid=0, with in_ready=1 the following cycle; entries are discarded.
REQ-035 rob_tag SHALL be sampled from rob_avail_num on the dequeue edge.

Reset
REQ-036 On rst, head, tail and count SHALL be 0 and all outputs SHALL be 0, except in_ready=1; rst SHALL override flush and rdy and abort any queued instructions mid-operation.

Verification
REQ-037 Directed scenario: push addi x5,x0,7 (0x00700293) with all avail flags high -> issue_valid 2 edges later, unit=00, op=op_addi, imm=7, rd=5, rs1=0, need_rs1=1, set_busy=1.
REQ-038 Directed scenario: push DEPTH instructions with rs_avail=0 -> in_ready=0 after the DEPTH-th acceptance; a push offered while full is not accepted; release rs_avail -> in-order issue, one per cycle, and in_ready returns to 1.
REQ-039 Directed scenario: sw x2,8(x1) with slb_avail=0 and rs_avail=1 -> no issue; raise slb_avail -> unit=01, inst_type=Store_Type, imm=8, rd=0, set_busy=0.
REQ-040 Directed scenario: 3 entries queued, assert flush for one cycle -> count=0, issue_valid=0, and no stale entry ever issues.
REQ-041 Directed scenario: opcode 0x7F -> issue_valid with unit=10 and illegal=1; add x0,x1,x2 -> set_busy=0.
REQ-042 Directed scenario: hold rdy=0 for 3 cycles with an instruction queued -> no state change; with DEPTH=8, 20 random push/pop cycles -> pointer wrap preserves FIFO order.
